mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum WAIT cycles before abort (range 2..255).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 ior_d  in  1  address select: 0 = pc, 1 = alu_out.
REQ-006 ir_write  in  1  instruction-fetch command.
REQ-007 mem_read  in  1  data-read command (load).
REQ-008 mem_write  in  1  data-write command (store).
REQ-009 pc, alu_out, wdata  in  WIDTH each  fetch address, data address, store data.
REQ-010 instr  out  WIDTH  instruction register.
REQ-011 mdr  out  WIDTH  memory data register.
REQ-012 stall  out  1  control unit SHALL hold its state while high.
REQ-013 bus_req, bus_we  out  1 each  bus request, write enable.
REQ-014 bus_addr, bus_wdata  out  WIDTH each  registered bus address, write data.
REQ-015 bus_rdata  in  WIDTH, bus_ack  in  1  read data, one-cycle completion strobe.
REQ-016 bus_err  out  1  one-cycle timeout pulse.
REQ-017 misalign  out  1  one-cycle alignment-fault pulse.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and FAULT.
REQ-019 In IDLE, any command high SHALL force stall = 1 combinationally and capture address, data and type at the next edge; the state SHALL then go to WAIT.
REQ-020 Command priority SHALL be mem_write > mem_read > ir_write; lower-priority commands in the same cycle are dropped.
REQ-021 The captured address SHALL be alu_out when ior_d = 1, else pc.
REQ-022 In WAIT: bus_req = 1; bus_addr, bus_wdata and bus_we SHALL be held stable; stall = !bus_ack.
REQ-023 On bus_ack in WAIT, bus_rdata SHALL be latched into instr (fetch) or mdr (read) at that edge; a write latches nothing; the state SHALL return to IDLE.
REQ-024 Minimum latency SHALL be 2 cycles (command cycle plus ack cycle); stall SHALL be low in the ack cycle.
REQ-025 The wait counter SHALL clear on WAIT entry and increment each WAIT cycle without ack.
REQ-026 When the count reaches TIMEOUT-1 without ack, the block SHALL drop bus_req, pulse bus_err, drive stall = 0 that cycle, leave instr/mdr unchanged, and return to IDLE.
REQ-027 bus_ack SHALL be ignored outside WAIT.
REQ-028 Ack and timeout in the same cycle SHALL be treated as ack.
REQ-029 A command still high in the cycle after return to IDLE SHALL start a new transaction.

Reset
REQ-030 While rst = 0: state = IDLE; instr, mdr, bus_addr, bus_wdata and the counter = 0; bus_req, bus_we, stall, bus_err and misalign = 0. This SHALL take effect immediately, including mid-transaction.

Configuration
REQ-031 Macro MAU_ALIGN_CHECK_EN defined: a selected address with [1:0] != 0 SHALL go to FAULT with no bus request; FAULT SHALL pulse misalign, hold stall = 0, and return to IDLE after one cycle.
REQ-032 Macro MAU_ALIGN_CHECK_EN undefined: bus_addr[1:0] SHALL be forced to 00, the FAULT state SHALL not exist, and misalign SHALL be tied 0.

Structure
REQ-033 Package mau_pkg SHALL hold the state encoding, the command-type encoding (FETCH/READ/WRITE), and the WIDTH/TIMEOUT defaults.
REQ-034 The wait counter SHALL be sub-module mau_timeout (inputs clear and enable; output expired).

Verification
REQ-035 Fetch: pc = 0x0000_0040, ir_write = 1, ack on the first WAIT cycle with rdata 0x2008_0005 -> bus_addr 0x40, stall high 1 cycle, instr = 0x2008_0005.
REQ-036 Store: ior_d = 1, alu_out = 0x100, wdata = 0xDEAD_BEEF, ack after 3 WAIT cycles -> bus_we = 1, data stable for 3 cycles, mdr unchanged.
REQ-037 Timeout: mem_read with no ack, TIMEOUT = 4 -> bus_err pulses in WAIT cycle 4, bus_req drops, mdr unchanged.
REQ-038 Priority: mem_write and ir_write both high -> bus_we = 1, instr unchanged.
REQ-039 Reset mid-WAIT: rst low two cycles after request -> bus_req = 0 immediately, instr = 0, state IDLE.
REQ-040 With MAU_ALIGN_CHECK_EN: alu_out = 0x102 read -> misalign pulse, no bus_req. Without the macro: bus_addr = 0x100.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the memory access unit: FSM states, command
// types and the write > read > fetch priority decode.
package mau_pkg;

   localparam int DEFAULT_WIDTH   = 32;
   localparam int DEFAULT_TIMEOUT = 16;

`ifdef MAU_ALIGN_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FAULT} stateT;
`else
   typedef enum logic [1:0] {S_IDLE, S_WAIT} stateT;
`endif

   typedef enum logic [1:0] {CMD_FETCH, CMD_READ, CMD_WRITE} cmdT;

   // Lower-priority commands raised in the same cycle are simply dropped
   function automatic cmdT cmdDecode(input logic memWrite, input logic memRead);
      if (memWrite) return CMD_WRITE;
      if (memRead)  return CMD_READ;
      return CMD_FETCH;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Control-unit command side and memory bus side of the memory access unit.
interface mem_access_unit_if #(parameter int WIDTH = mau_pkg::DEFAULT_WIDTH) ();

   logic             ior_d;
   logic             ir_write;
   logic             mem_read;
   logic             mem_write;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] instr;
   logic [WIDTH-1:0] mdr;
   logic             stall;
   logic             bus_req;
   logic             bus_we;
   logic [WIDTH-1:0] bus_addr;
   logic [WIDTH-1:0] bus_wdata;
   logic [WIDTH-1:0] bus_rdata;
   logic             bus_ack;
   logic             bus_err;
   logic             misalign;

   modport master (
      output ior_d, ir_write, mem_read, mem_write, pc, alu_out, wdata, bus_rdata, bus_ack,
      input  instr, mdr, stall, bus_req, bus_we, bus_addr, bus_wdata, bus_err, misalign
   );

   modport slave (
      input  ior_d, ir_write, mem_read, mem_write, pc, alu_out, wdata, bus_rdata, bus_ack,
      output instr, mdr, stall, bus_req, bus_we, bus_addr, bus_wdata, bus_err, misalign
   );

endinterface

// File: rtl/mem_access_unit_timeout.sv
// Wait-cycle counter for the memory access unit; expired is high once the
// count reaches TIMEOUT-1.
module mau_timeout #(
   parameter int TIMEOUT = mau_pkg::DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= 8'd0;
      end else if (clear) begin
         r_count <= 8'd0;
      end else if (enable) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign expired = (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access unit: turns fetch/load/store commands into a bus
// transaction with stall, ack latching and timeout. MAU_ALIGN_CHECK_EN adds a FAULT path.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);

   stateT            r_state;
   stateT            w_nextState;
   cmdT              r_cmdType;
   cmdT              w_cmd;
   logic [WIDTH-1:0] r_instr;
   logic [WIDTH-1:0] r_mdr;
   logic [WIDTH-1:0] r_busAddr;
   logic [WIDTH-1:0] r_busWdata;
   logic [WIDTH-1:0] w_selAddr;
   logic [WIDTH-1:0] w_captureAddr;
   logic             w_anyCmd;
   logic             w_capture;
   logic             w_expired;
   logic             w_stall;
   logic             w_busReq;
   logic             w_busErr;
`ifdef MAU_ALIGN_CHECK_EN
   logic             w_misaligned;
   logic             w_misalign;
`endif

   assign w_anyCmd  = bus.mem_write | bus.mem_read | bus.ir_write;
   assign w_cmd     = cmdDecode(bus.mem_write, bus.mem_read);
   assign w_selAddr = bus.ior_d ? bus.alu_out : bus.pc;

`ifdef MAU_ALIGN_CHECK_EN
   assign w_misaligned  = |w_selAddr[1:0];
   assign w_captureAddr = w_selAddr;
`else
   // Without the alignment check the low address bits are forced to word alignment
   assign w_captureAddr = w_selAddr & ~(WIDTH'(3));
`endif

   mau_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (r_state != S_WAIT),
      .enable  ((r_state == S_WAIT) && !bus.bus_ack),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      w_stall     = 1'b0;
      w_busReq    = 1'b0;
      w_busErr    = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
      w_misalign  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_anyCmd) begin
               w_stall = 1'b1;
`ifdef MAU_ALIGN_CHECK_EN
               if (w_misaligned) begin
                  w_nextState = S_FAULT;
               end else begin
                  w_capture   = 1'b1;
                  w_nextState = S_WAIT;
               end
`else
               w_capture   = 1'b1;
               w_nextState = S_WAIT;
`endif
            end
         end
         // Ack wins over a timeout landing in the same cycle
         S_WAIT: begin
            w_busReq = 1'b1;
            if (bus.bus_ack) begin
               w_nextState = S_IDLE;
            end else if (w_expired) begin
               w_busReq    = 1'b0;
               w_busErr    = 1'b1;
               w_nextState = S_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
`ifdef MAU_ALIGN_CHECK_EN
         S_FAULT: begin
            w_misalign  = 1'b1;
            w_nextState = S_IDLE;
         end
`endif
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_instr    <= '0;
         r_mdr      <= '0;
         r_busAddr  <= '0;
         r_busWdata <= '0;
         r_cmdType  <= CMD_FETCH;
      end else begin
         if (w_capture) begin
            r_busAddr  <= w_captureAddr;
            r_busWdata <= bus.wdata;
            r_cmdType  <= w_cmd;
         end
         if ((r_state == S_WAIT) && bus.bus_ack) begin
            if (r_cmdType == CMD_FETCH) begin
               r_instr <= bus.bus_rdata;
            end else if (r_cmdType == CMD_READ) begin
               r_mdr <= bus.bus_rdata;
            end
         end
      end
   end

   // The IDLE stall is combinational from the commands, so gate it during reset
   assign bus.stall     = rst & w_stall;
   assign bus.bus_req   = w_busReq;
   assign bus.bus_we    = w_busReq && (r_cmdType == CMD_WRITE);
   assign bus.bus_err   = w_busErr;
   assign bus.bus_addr  = r_busAddr;
   assign bus.bus_wdata = r_busWdata;
   assign bus.instr     = r_instr;
   assign bus.mdr       = r_mdr;
`ifdef MAU_ALIGN_CHECK_EN
   assign bus.misalign  = w_misalign;
`else
   assign bus.misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit with TIMEOUT = 4; the alignment
// vectors follow MAU_ALIGN_CHECK_EN.
module tb_mem_access_unit;

   logic clk;
   logic rst;
   int   vectorsApplied;
   int   miscompares;

   mem_access_unit_if #(.WIDTH(32)) busIf ();

   mem_access_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic iorD, input logic irWrite, input logic memRead,
                                input logic memWrite, input logic [31:0] pc,
                                input logic [31:0] aluOut, input logic [31:0] wdata);
      busIf.ior_d     = iorD;
      busIf.ir_write  = irWrite;
      busIf.mem_read  = memRead;
      busIf.mem_write = memWrite;
      busIf.pc        = pc;
      busIf.alu_out   = aluOut;
      busIf.wdata     = wdata;
      #1;
   endtask

   task automatic setAck(input logic ack, input logic [31:0] rdata);
      busIf.bus_ack   = ack;
      busIf.bus_rdata = rdata;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCommands;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      vectorsApplied = 0;
      miscompares    = 0;
      rst            = 1'b0;
      setAck(1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);

      // Reset state, with a command held high to confirm stall stays low
      checkOutput("rst_instr",    busIf.instr,    32'h0);
      checkOutput("rst_mdr",      busIf.mdr,      32'h0);
      checkOutput("rst_bus_addr", busIf.bus_addr, 32'h0);
      checkOutput("rst_bus_req",  32'(busIf.bus_req),  32'h0);
      checkOutput("rst_stall",    32'(busIf.stall),    32'h0);
      checkOutput("rst_bus_err",  32'(busIf.bus_err),  32'h0);
      checkOutput("rst_misalign", 32'(busIf.misalign), 32'h0);
      tick();
      tick();
      idleCommands();
      rst = 1'b1;
      #1;

      // Fetch, ack in the first WAIT cycle
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
      checkOutput("fetch_stall_cmd", 32'(busIf.stall), 32'h1);
      tick();
      idleCommands();
      setAck(1'b1, 32'h2008_0005);
      checkOutput("fetch_bus_req",   32'(busIf.bus_req), 32'h1);
      checkOutput("fetch_bus_addr",  busIf.bus_addr, 32'h40);
      checkOutput("fetch_stall_ack", 32'(busIf.stall), 32'h0);
      tick();
      setAck(1'b0, 32'h0);
      checkOutput("fetch_instr",     busIf.instr, 32'h2008_0005);
      checkOutput("fetch_req_done",  32'(busIf.bus_req), 32'h0);

      // Load from alu_out, ack in the second WAIT cycle
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h200, 32'h0);
      tick();
      idleCommands();
      checkOutput("read_bus_addr", busIf.bus_addr, 32'h200);
      checkOutput("read_bus_we",   32'(busIf.bus_we), 32'h0);
      checkOutput("read_stall_w1", 32'(busIf.stall), 32'h1);
      tick();
      setAck(1'b1, 32'hCAFE_0001);
      tick();
      setAck(1'b0, 32'h0);
      checkOutput("read_mdr",   busIf.mdr,   32'hCAFE_0001);
      checkOutput("read_instr", busIf.instr, 32'h2008_0005);

      // Store, ack in the third WAIT cycle, bus data held stable meanwhile
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h48, 32'h100, 32'hDEAD_BEEF);
      checkOutput("store_stall_cmd", 32'(busIf.stall), 32'h1);
      tick();
      idleCommands();
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) setAck(1'b1, 32'h1234_5678);
         checkOutput($sformatf("store_we_w%0d", k),    32'(busIf.bus_we),  32'h1);
         checkOutput($sformatf("store_req_w%0d", k),   32'(busIf.bus_req), 32'h1);
         checkOutput($sformatf("store_addr_w%0d", k),  busIf.bus_addr,  32'h100);
         checkOutput($sformatf("store_wdata_w%0d", k), busIf.bus_wdata, 32'hDEAD_BEEF);
         checkOutput($sformatf("store_stall_w%0d", k), 32'(busIf.stall), (k < 3) ? 32'h1 : 32'h0);
         tick();
      end
      setAck(1'b0, 32'h0);
      checkOutput("store_mdr",    busIf.mdr, 32'hCAFE_0001);
      checkOutput("store_we_off", 32'(busIf.bus_we), 32'h0);

      // Load that never sees an ack times out in WAIT cycle 4
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0);
      tick();
      idleCommands();
      for (int k = 1; k <= 4; k++) begin
         checkOutput($sformatf("tmo_req_w%0d", k),   32'(busIf.bus_req), (k < 4) ? 32'h1 : 32'h0);
         checkOutput($sformatf("tmo_err_w%0d", k),   32'(busIf.bus_err), (k < 4) ? 32'h0 : 32'h1);
         checkOutput($sformatf("tmo_stall_w%0d", k), 32'(busIf.stall),   (k < 4) ? 32'h1 : 32'h0);
         tick();
      end
      checkOutput("tmo_err_after", 32'(busIf.bus_err), 32'h0);
      checkOutput("tmo_req_after", 32'(busIf.bus_req), 32'h0);
      checkOutput("tmo_mdr",       busIf.mdr, 32'hCAFE_0001);

      // Store outranks fetch in the same cycle
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 32'h0000_0055);
      tick();
      idleCommands();
      checkOutput("prio_bus_we",    32'(busIf.bus_we), 32'h1);
      checkOutput("prio_bus_wdata", busIf.bus_wdata, 32'h0000_0055);
      setAck(1'b1, 32'hFFFF_0000);
      tick();
      setAck(1'b0, 32'h0);
      checkOutput("prio_instr", busIf.instr, 32'h2008_0005);

      // Reset asserted two cycles into a fetch
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0);
      tick();
      idleCommands();
      tick();
      checkOutput("rstw_req_before", 32'(busIf.bus_req), 32'h1);
      rst = 1'b0;
      #1;
      checkOutput("rstw_bus_req", 32'(busIf.bus_req), 32'h0);
      checkOutput("rstw_instr",   busIf.instr, 32'h0);
      checkOutput("rstw_stall",   32'(busIf.stall), 32'h0);
      tick();
      rst = 1'b1;
      #1;
      tick();
      checkOutput("rstw_idle_req", 32'(busIf.bus_req), 32'h0);

      // Misaligned data address
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h102, 32'h0);
`ifdef MAU_ALIGN_CHECK_EN
      tick();
      idleCommands();
      checkOutput("align_misalign", 32'(busIf.misalign), 32'h1);
      checkOutput("align_no_req",   32'(busIf.bus_req),  32'h0);
      checkOutput("align_stall",    32'(busIf.stall),    32'h0);
      tick();
      checkOutput("align_pulse_end", 32'(busIf.misalign), 32'h0);
      checkOutput("align_idle_req",  32'(busIf.bus_req),  32'h0);
`else
      tick();
      idleCommands();
      checkOutput("align_bus_addr", busIf.bus_addr, 32'h100);
      checkOutput("align_bus_req",  32'(busIf.bus_req), 32'h1);
      checkOutput("align_misalign", 32'(busIf.misalign), 32'h0);
      setAck(1'b1, 32'h0BAD_F00D);
      tick();
      setAck(1'b0, 32'h0);
      checkOutput("align_mdr", busIf.mdr, 32'h0BAD_F00D);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
